// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request in flight, variable-latency word memory port.
// Optional feature macro: LSU_TIMEOUT_EN (bounds the WAIT state by TIMEOUT_CYCLES).
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [4:0]        rsp_rd,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_misaligned,
    output logic              rsp_timeout
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [XLEN-1:0]   XLEN_ONE  = 1;
    localparam logic [STRB_W-1:0] STRB_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(STRB_W - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, next_state;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [4:0]        rd_q;
    logic              fault_q;
    logic              timeout_q;
    logic [XLEN-1:0]   data_q;

    logic              accept;
    logic              req_fault;
    logic              wait_expired;
    logic [OFF_W-1:0]  off;
    int unsigned       nbytes;
    int unsigned       nbits;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   lane_mask;
    logic [XLEN-1:0]   load_ext;
    logic [XLEN-1:0]   wdata_rep;
    logic [STRB_W-1:0] strb;
    logic              sign_bit;

    assign accept = req_valid && req_ready;

    always_comb begin
        req_fault = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_fault = req_addr[0];
            2'b10:   req_fault = |req_addr[1:0];
            2'b11:   req_fault = (|req_addr[2:0]) || (XLEN == 32);
            default: req_fault = 1'b0;
        endcase
        if (req_funct3 == 3'b111 || (req_is_store && req_funct3[2]) ||
            (XLEN == 32 && req_funct3 == 3'b110))
            req_fault = 1'b1;
    end

    // Lane datapath works off the latched request; the sign bit is the top bit of the lane mask.
    always_comb begin
        off       = addr_q[OFF_W-1:0];
        nbytes    = 32'd1 << funct3_q[1:0];
        nbits     = 32'd8 << funct3_q[1:0];
        lane_mask = (XLEN_ONE << nbits) - XLEN_ONE;
        shifted   = mem_rdata >> {off, 3'b000};
        sign_bit  = |(shifted & (lane_mask ^ (lane_mask >> 1)));
        load_ext  = shifted & lane_mask;
        if (!funct3_q[2] && sign_bit)
            load_ext = load_ext | ~lane_mask;
        strb      = ((STRB_ONE << nbytes) - STRB_ONE) << off;
        wdata_rep = wdata_q & lane_mask;
        for (int unsigned s = 8; s < XLEN; s = s * 2) begin
            if (s >= nbits)
                wdata_rep = wdata_rep | (wdata_rep << s);
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    logic [CNT_W-1:0] wait_cnt;

    assign wait_expired = (state == WAIT) && !mem_rsp_valid &&
                          (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != WAIT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (accept)
                timeout_q <= 1'b0;
            else if (wait_expired)
                timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wait_expired       = 1'b0;
    assign timeout_q          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            fault_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            if (accept) begin
                is_store_q <= req_is_store;
                funct3_q   <= req_funct3;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rd_q       <= req_rd;
                fault_q    <= req_fault;
                data_q     <= '0;
            end
            if (state == WAIT && mem_rsp_valid)
                data_q <= load_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = req_fault ? DONE : ISSUE;
            ISSUE:   if (mem_req_ready) next_state = is_store_q ? DONE : WAIT;
            WAIT:    if (mem_rsp_valid || wait_expired) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        mem_req_valid  = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wstrb      = '0;
        rsp_valid      = 1'b0;
        rsp_rd         = '0;
        rsp_data       = '0;
        rsp_misaligned = 1'b0;
        rsp_timeout    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:  req_ready = 1'b1;
                ISSUE: begin
                    mem_req_valid = 1'b1;
                    mem_we        = is_store_q;
                    mem_addr      = addr_q & ~ADDR_MASK;
                    if (is_store_q) begin
                        mem_wdata = wdata_rep;
                        mem_wstrb = strb;
                    end
                end
                DONE: begin
                    rsp_valid      = 1'b1;
                    rsp_rd         = rd_q;
                    rsp_data       = data_q;
                    rsp_misaligned = fault_q;
                    rsp_timeout    = timeout_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, randomized traffic against a
// rule-level reference model, reset abort and WAIT timeout (LSU_TIMEOUT_EN aware).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_misaligned, rsp_timeout;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
        .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout)
    );

    int tests_run = 0;
    int fails = 0;

    logic        obs_ready, obs_issued, obs_we, obs_unstable, obs_mis, obs_to;
    logic        obs_after, obs_ready_after;
    logic [31:0] obs_addr, obs_wdata, obs_data;
    logic [3:0]  obs_strb;
    logic [4:0]  obs_rd;
    int          obs_latency;

    // Reference model, written straight from the width/alignment/extension rules.
    function automatic logic exp_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int unsigned n;
        if (f3 == 3'b111 || f3 == 3'b011 || f3 == 3'b110) return 1'b1;
        if (st && f3[2]) return 1'b1;
        n = 1 << f3[1:0];
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b100:  return {24'h0, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b101:  return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        int unsigned off, n;
        off = a % 4;
        n = 1 << f3[1:0];
        s = '0;
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + n) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Drives one request and plays the memory side; records what the DUT did.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                           input int stall, input int delay, input int budget);
        int stalled, waited;
        logic waiting, go_wait, first;
        obs_ready = req_ready; obs_issued = 0; obs_latency = -1; obs_unstable = 0;
        obs_we = 0; obs_addr = '0; obs_wdata = '0; obs_strb = '0;
        obs_data = 'x; obs_mis = 'x; obs_to = 'x; obs_rd = 'x;
        req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        stalled = 0; waited = 0; waiting = 0; first = 1;
        for (int k = 1; k <= budget; k++) begin
            if (rsp_valid) begin
                obs_latency = k; obs_data = rsp_data; obs_mis = rsp_misaligned;
                obs_to = rsp_timeout; obs_rd = rsp_rd;
                break;
            end
            mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = $urandom; go_wait = 0;
            if (mem_req_valid) begin
                obs_issued = 1;
                mem_rsp_valid = 1'($urandom);
                if (first) begin
                    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
                    obs_strb = mem_wstrb; first = 0;
                end else if (obs_we !== mem_we || obs_addr !== mem_addr ||
                             obs_wdata !== mem_wdata || obs_strb !== mem_wstrb) begin
                    obs_unstable = 1;
                end
                if (stalled >= stall) begin
                    mem_req_ready = 1;
                    go_wait = !st;
                end else begin
                    stalled++;
                end
            end else if (waiting) begin
                if (waited >= delay) begin
                    mem_rsp_valid = 1; mem_rdata = rdata;
                end else begin
                    waited++;
                end
            end
            @(posedge clk); #1;
            if (go_wait) waiting = 1;
        end
        mem_req_ready = 0; mem_rsp_valid = 0;
        @(posedge clk); #1;
        obs_after = rsp_valid; obs_ready_after = req_ready;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 1; req_is_store = 1; req_funct3 = 3'b010; req_addr = 32'h100;
        req_wdata = 32'hFFFF_FFFF; req_rd = 5'd9; mem_req_ready = 1; mem_rsp_valid = 1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_valid,
             rsp_rd, rsp_data, rsp_misaligned, rsp_timeout} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b mreq=%b addr=%h strb=%h rsp=%b data=%h expected all zero",
                     req_ready, mem_req_valid, mem_addr, mem_wstrb, rsp_valid, rsp_data);
        end
        req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0; rst = 0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_txn(0, 3'b010, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0, 0, 20);
        tests_run++; if (obs_latency !== 3) begin fails++; $display("FAIL lw_latency: got %0d expected 3", obs_latency); end
        tests_run++; if (obs_addr !== 32'h100) begin fails++; $display("FAIL lw_addr: got %h expected 00000100", obs_addr); end
        tests_run++; if (obs_strb !== 4'b0000 || obs_we !== 1'b0) begin fails++; $display("FAIL lw_strb_we: got %b/%b expected 0000/0", obs_strb, obs_we); end
        tests_run++; if (obs_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data: got %h expected deadbeef", obs_data); end
        tests_run++; if (obs_rd !== 5'd7) begin fails++; $display("FAIL lw_rd: got %0d expected 7", obs_rd); end
        tests_run++; if (obs_after !== 1'b0 || obs_ready_after !== 1'b1) begin fails++; $display("FAIL lw_pulse: got rsp=%b ready=%b expected 0/1", obs_after, obs_ready_after); end

        run_txn(0, 3'b000, 32'h103, 32'h0, 5'd1, 32'h80FFFFFF, 0, 0, 20);
        tests_run++; if (obs_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data: got %h expected ffffff80", obs_data); end
        run_txn(0, 3'b100, 32'h103, 32'h0, 5'd2, 32'h80FFFFFF, 0, 0, 20);
        tests_run++; if (obs_data !== 32'h00000080) begin fails++; $display("FAIL lbu_data: got %h expected 00000080", obs_data); end
        run_txn(0, 3'b101, 32'h102, 32'h0, 5'd3, 32'h80FFFFFF, 0, 0, 20);
        tests_run++; if (obs_data !== 32'h000080FF) begin fails++; $display("FAIL lhu_data: got %h expected 000080ff", obs_data); end

        run_txn(1, 3'b001, 32'h202, 32'h1234ABCD, 5'd4, 32'h0, 3, 0, 20);
        tests_run++; if (obs_strb !== 4'b1100) begin fails++; $display("FAIL sh_strb: got %b expected 1100", obs_strb); end
        tests_run++; if (obs_wdata !== 32'hABCDABCD) begin fails++; $display("FAIL sh_wdata: got %h expected abcdabcd", obs_wdata); end
        tests_run++; if (obs_we !== 1'b1 || obs_addr !== 32'h200) begin fails++; $display("FAIL sh_we_addr: got %b/%h expected 1/00000200", obs_we, obs_addr); end
        tests_run++; if (obs_unstable !== 1'b0) begin fails++; $display("FAIL sh_stable: got unstable=%b expected 0", obs_unstable); end
        tests_run++; if (obs_latency !== 5 || obs_data !== 32'h0) begin fails++; $display("FAIL sh_latency_data: got %0d/%h expected 5/00000000", obs_latency, obs_data); end

        run_txn(0, 3'b010, 32'h101, 32'h0, 5'd5, 32'hFFFFFFFF, 0, 0, 20);
        tests_run++; if (obs_issued !== 1'b0) begin fails++; $display("FAIL mis_no_issue: got issued=%b expected 0", obs_issued); end
        tests_run++; if (obs_latency !== 1 || obs_mis !== 1'b1 || obs_data !== 32'h0) begin
            fails++; $display("FAIL mis_rsp: got lat=%0d mis=%b data=%h expected 1/1/00000000", obs_latency, obs_mis, obs_data);
        end
    endtask

    task automatic test_random_traffic();
        logic st, f;
        logic [2:0] f3;
        logic [31:0] a, w, rdv, ed;
        logic [4:0] rd;
        int stall, delay, el;
        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom); f3 = 3'($urandom_range(0, 7)); a = $urandom; w = $urandom;
            rdv = $urandom; rd = 5'($urandom); stall = $urandom_range(0, 2); delay = $urandom_range(0, 2);
            f = exp_fault(st, f3, a);
            el = f ? 1 : (st ? 2 + stall : 3 + stall + delay);
            ed = (f || st) ? 32'h0 : exp_load(f3, a, rdv);
            run_txn(st, f3, a, w, rd, rdv, stall, delay, 30);
            tests_run++;
            if (obs_latency !== el || obs_ready !== 1'b1 || obs_issued !== !f) begin
                fails++; $display("FAIL rand_handshake[%0d]: got lat=%0d ready=%b issued=%b expected %0d/1/%b", i, obs_latency, obs_ready, obs_issued, el, !f);
            end
            tests_run++;
            if (obs_data !== ed || obs_mis !== f || obs_rd !== rd || obs_to !== 1'b0) begin
                fails++; $display("FAIL rand_rsp[%0d]: got data=%h mis=%b rd=%0d to=%b expected %h/%b/%0d/0", i, obs_data, obs_mis, obs_rd, obs_to, ed, f, rd);
            end
            if (!f) begin
                tests_run++;
                if (obs_addr !== (a & ~32'h3) || obs_we !== st || obs_unstable !== 1'b0) begin
                    fails++; $display("FAIL rand_issue[%0d]: got addr=%h we=%b unstable=%b expected %h/%b/0", i, obs_addr, obs_we, obs_unstable, a & ~32'h3, st);
                end
            end
            if (!f && st) begin
                tests_run++;
                if (obs_strb !== exp_strb(f3, a) || obs_wdata !== exp_wdata(f3, w)) begin
                    fails++; $display("FAIL rand_store[%0d]: got strb=%b wdata=%h expected %b/%h", i, obs_strb, obs_wdata, exp_strb(f3, a), exp_wdata(f3, w));
                end
            end
        end
    endtask

    task automatic test_abort();
        int bad;
        req_valid = 1; req_is_store = 0; req_funct3 = 3'b010; req_addr = 32'h40; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 0;
        tests_run++; if (mem_req_valid !== 1'b1) begin fails++; $display("FAIL abort_issue: got mreq=%b expected 1", mem_req_valid); end
        mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        tests_run++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL abort_in_rst: got ready=%b rsp=%b expected 0/0", req_ready, rsp_valid); end
        rst = 0;
        #1;
        tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
        mem_rsp_valid = 1; mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid || mem_req_valid) bad++;
            @(posedge clk); #1;
        end
        tests_run++; if (bad !== 0) begin fails++; $display("FAIL abort_late_rsp: got %0d active cycles expected 0", bad); end

        req_valid = 1; req_is_store = 1; req_funct3 = 3'b010; req_addr = 32'h80; req_wdata = $urandom;
        @(posedge clk); #1;
        req_valid = 0; mem_req_ready = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        tests_run++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL abort_issue_drop: got mreq=%b ready=%b expected 0/1", mem_req_valid, req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
        run_txn(0, 3'b010, 32'h300, 32'h0, 5'd11, 32'h12345678, 0, 1000, 20);
        tests_run++;
        if (obs_latency !== 6 || obs_to !== 1'b1 || obs_data !== 32'h0 || obs_mis !== 1'b0) begin
            fails++; $display("FAIL timeout_fire: got lat=%0d to=%b data=%h mis=%b expected 6/1/00000000/0", obs_latency, obs_to, obs_data, obs_mis);
        end
        run_txn(0, 3'b010, 32'h304, 32'h0, 5'd12, 32'hCAFEF00D, 0, 3, 20);
        tests_run++;
        if (obs_latency !== 6 || obs_to !== 1'b0 || obs_data !== 32'hCAFEF00D) begin
            fails++; $display("FAIL timeout_terminal_rsp: got lat=%0d to=%b data=%h expected 6/0/cafef00d", obs_latency, obs_to, obs_data);
        end
`else
        run_txn(0, 3'b010, 32'h300, 32'h0, 5'd11, 32'h12345678, 0, 1000, 40);
        tests_run++;
        if (obs_latency !== -1 || obs_issued !== 1'b1) begin
            fails++; $display("FAIL wait_forever: got lat=%0d issued=%b expected -1/1", obs_latency, obs_issued);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random_traffic();
        test_abort();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
